// File: rtl/cape_pkg.sv
`default_nettype none
// ============================================================================
// Module   : cape_pkg
// Brief    : Shared state type and helper functions for the CAPE stream generator.
// Revision : 1.0 - initial release
// ============================================================================
package cape_pkg;

    typedef enum logic {IDLE, RUN} cape_state_t;

    // Helpers work on 32-bit containers, so CW must not exceed 32.
    localparam int MAX_W = 32;

    // Index of the lowest set bit among the low w bits; w when none is set.
    function automatic int tz(input logic [MAX_W-1:0] v, input int w);
        int r;
        r = w;
        for (int k = MAX_W - 1; k >= 0; k--) begin
            if (k < w && ((v >> k) & 1) != 0) begin
                r = k;
            end
        end
        return r;
    endfunction

    // Gather channel ch's compare value: bit j comes from counter bit j*n+ch.
    function automatic logic [MAX_W-1:0] cape_interleave(input logic [MAX_W-1:0] cnt,
                                                         input int ch, input int n,
                                                         input int w);
        logic [MAX_W-1:0] c;
        c = '0;
        for (int j = 0; j < MAX_W; j++) begin
            if (j < w) begin
                c = c | (((cnt >> (j * n + ch)) & 1) << j);
            end
        end
        return c;
    endfunction

endpackage
`default_nettype wire

// File: rtl/cape_stream_gen_if.sv
`default_nettype none
// ============================================================================
// Module   : cape_stream_gen_if
// Brief    : Control, operand and stream handshake bundle of the generator.
// Revision : 1.0 - initial release
// ============================================================================
interface cape_stream_gen_if #(
    parameter int WIDTH      = 4,
    parameter int NUM_INPUTS = 2
);
    logic                          start;
    logic                          mode;
    logic [WIDTH-1:0]              trunc;
    logic [WIDTH-1:0]              Bxs [NUM_INPUTS-1:0];
    logic                          ready;
    logic                          valid;
    logic [NUM_INPUTS-1:0]         Xs;
    logic                          busy;
    logic                          done;
    logic [WIDTH*NUM_INPUTS:0]     len;

    modport master (
        input  start, mode, trunc, Bxs, ready,
        output valid, Xs, busy, done, len
    );

    modport slave (
        output start, mode, trunc, Bxs, ready,
        input  valid, Xs, busy, done, len
    );
endinterface
`default_nettype wire

// File: rtl/cape_bp_ctr.sv
`default_nettype none
// ============================================================================
// Module   : cape_bp_ctr
// Brief    : Counter whose increment carry skips bypassed bits (held at 0).
// Revision : 1.0 - initial release
// ============================================================================
module cape_bp_ctr #(
    parameter int CW = 8
) (
    input  wire logic          clk,
    input  wire logic          rst_n,
    input  wire logic          en,
    input  wire logic          clr,
    input  wire logic [CW-1:0] bp,
    output logic      [CW-1:0] cnt,
    output logic               last
);
    logic [CW-1:0] r_cnt;
    logic [CW-1:0] w_next;

    // Forcing bypassed bits to 1 lets the carry ripple straight through them.
    assign w_next = ((r_cnt | bp) + CW'(1)) & ~bp;
    assign last   = &(r_cnt | bp);
    assign cnt    = r_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (clr) begin
            r_cnt <= '0;
        end else if (en) begin
            r_cnt <= w_next;
        end
    end
endmodule
`default_nettype wire

// File: rtl/cape_stream_gen.sv
`default_nettype none
// ============================================================================
// Module   : cape_stream_gen
// Brief    : Run-controlled CAPE stochastic bitstream generator with ET mode.
// Revision : 1.0 - initial release
// ============================================================================
module cape_stream_gen
    import cape_pkg::*;
#(
    parameter int WIDTH      = 4,
    parameter int NUM_INPUTS = 2
) (
    input  wire logic          clk,
    input  wire logic          rst_n,
    cape_stream_gen_if.master  sif
);
    localparam int          CW      = WIDTH * NUM_INPUTS;
    localparam logic [CW:0] LEN_MAX = {1'b1, {CW{1'b0}}};
    localparam logic [CW:0] LEN_ONE = {{CW{1'b0}}, 1'b1};

    cape_state_t        r_state;
    cape_state_t        w_state_nxt;
    logic [WIDTH-1:0]   r_bq [NUM_INPUTS-1:0];
    logic               r_mode;
    logic               r_done;
    logic [CW:0]        r_len;

    logic               w_valid;
    logic               w_fire;
    logic               w_latch;
    logic               w_finish;
    logic               w_last;
    logic [CW-1:0]      w_bp;
    logic [CW-1:0]      w_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_latch     = 1'b0;
        w_finish    = 1'b0;
        w_valid     = 1'b0;
        case (r_state)
            IDLE: begin
                if (sif.start) begin
                    w_latch     = 1'b1;
                    w_state_nxt = RUN;
                end
            end
            RUN: begin
                w_valid = 1'b1;
                if (sif.ready && w_last) begin
                    w_finish    = 1'b1;
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    assign w_fire = w_valid & sif.ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_INPUTS; i++) begin
                r_bq[i] <= '0;
            end
            r_mode <= 1'b0;
            r_done <= 1'b0;
            r_len  <= '0;
        end else begin
            r_done <= w_finish;
            if (w_latch) begin
                for (int i = 0; i < NUM_INPUTS; i++) begin
                    r_bq[i] <= sif.Bxs[i] & ~sif.trunc;
                end
                r_mode <= sif.mode;
                r_len  <= '0;
            end else if (w_fire && r_len != LEN_MAX) begin
                r_len <= r_len + LEN_ONE;
            end
        end
    end

    cape_bp_ctr #(
        .CW (CW)
    ) u_ctr (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (w_fire),
        .clr   (w_latch),
        .bp    (w_bp),
        .cnt   (w_cnt),
        .last  (w_last)
    );

    // In ET mode a channel's bits below its lowest set operand bit never
    // change the compare outcome, so they are skipped.
    for (genvar i = 0; i < NUM_INPUTS; i++) begin : g_chan
        logic [WIDTH-1:0] w_ci;

        assign w_ci       = WIDTH'(cape_interleave(32'(w_cnt), i, NUM_INPUTS, WIDTH));
        assign sif.Xs[i]  = w_valid & (w_ci < r_bq[i]);

        for (genvar j = 0; j < WIDTH; j++) begin : g_bit
            assign w_bp[j*NUM_INPUTS+i] = r_mode & (j < tz(32'(r_bq[i]), WIDTH));
        end
    end

    assign sif.valid = w_valid;
    assign sif.busy  = (r_state == RUN);
    assign sif.done  = r_done;
    assign sif.len   = r_len;
endmodule
`default_nettype wire
